// File: rtl/hazard_sched.sv
// hazard_sched: decode-stage hazard controller with load scoreboard, stall/flush FSM and operand forwarding select
module hazard_sched #(
  parameter int RegAddress = 5,
  parameter int NumRegs = 2**RegAddress,
  parameter int MaxLoads = 2,
  parameter int FlushCycles = 2,
  parameter int TimeoutCycles = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [RegAddress-1:0] id_rs1,
  input  logic [RegAddress-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [RegAddress-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_load,
  input  logic [RegAddress-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_load,
  input  logic [RegAddress-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  lsu_rsp_valid,
  input  logic [RegAddress-1:0] lsu_rsp_rd,
  input  logic                  redirect,
  output logic                  pc_stall,
  output logic                  id_stall,
  output logic                  id_flush,
  output logic                  ex_bubble,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [1:0]            hz_state,
  output logic [31:0]           stall_count,
  output logic                  timeout_err
);
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;
  state_t state, state_nxt;
  logic [NumRegs-1:0] pend, pend_nxt;
  logic [2:0] load_cnt, flush_cnt, flush_cnt_nxt;
  logic [31:0] stall_run, run_nxt;
  logic hazard, issue, rsp_ok;
  function automatic logic [1:0] fwd(input logic [RegAddress-1:0] rs);
    return (ex_reg_write && !ex_load && ex_rd == rs && ex_rd != '0) ? 2'b01 :
           (wb_reg_write && wb_rd == rs && wb_rd != '0) ? 2'b10 : 2'b00;
  endfunction
  assign hazard = id_valid && ((id_use_rs1 && id_rs1 != '0 && pend[id_rs1]) ||
                               (id_use_rs2 && id_rs2 != '0 && pend[id_rs2]) ||
                               (id_reg_write && id_rd != '0 && pend[id_rd]) ||
                               (id_load && load_cnt == 3'(MaxLoads)));
  // reset forces the squash/bubble so nothing leaks into EX while state is cleared
  assign id_flush = !rst || redirect || state == FLUSH;
  assign id_stall = hazard && !id_flush;
  assign pc_stall = id_stall;
  assign ex_bubble = id_stall || id_flush;
  assign issue = id_valid && !hazard && !id_flush;
  assign rsp_ok = lsu_rsp_valid && load_cnt != '0;
  assign hz_state = state;
  always_comb begin
    fwd_a_sel = rst ? fwd(id_rs1) : 2'b00;
    fwd_b_sel = rst ? fwd(id_rs2) : 2'b00;
  end
  always_comb begin
    pend_nxt = pend;
    if (lsu_rsp_valid) pend_nxt[lsu_rsp_rd] = 1'b0;
    if (issue && id_load && id_rd != '0) pend_nxt[id_rd] = 1'b1;
  end
  always_comb begin
    state_nxt = state;
    flush_cnt_nxt = flush_cnt;
    if (redirect && FlushCycles > 1) begin
      state_nxt = FLUSH;
      flush_cnt_nxt = 3'(FlushCycles - 1);
    end else if (state == FLUSH) begin
      flush_cnt_nxt = flush_cnt - 3'd1;
      state_nxt = flush_cnt == 3'd1 ? RUN : FLUSH;
    end else begin
      state_nxt = id_stall ? STALL : RUN;
    end
  end
  always_comb run_nxt = !id_stall ? '0 : stall_run >= 32'(TimeoutCycles) ? stall_run : stall_run + 32'd1;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      flush_cnt <= '0;
      pend <= '0;
      load_cnt <= '0;
      stall_run <= '0;
      stall_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      pend <= pend_nxt;
      load_cnt <= load_cnt + 3'(issue && id_load) - 3'(rsp_ok);
      stall_run <= run_nxt;
      stall_count <= stall_count + 32'(id_stall && stall_count != '1);
      timeout_err <= timeout_err || run_nxt >= 32'(TimeoutCycles);
    end
  end
endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: scoreboard bench for hazard_sched; expected outputs queued per driven cycle, compared at negedge
module tb_hazard_sched;
  logic clk = 1'b0, rst;
  logic id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_load;
  logic ex_reg_write, ex_load, wb_reg_write, lsu_rsp_valid, redirect;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, wb_rd, lsu_rsp_rd;
  logic pc_stall, id_stall, id_flush, ex_bubble, timeout_err;
  logic [1:0] fwd_a_sel, fwd_b_sel, hz_state;
  logic [31:0] stall_count;
  typedef struct {
    string tag;
    logic [10:0] v;
    logic [31:0] c;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  logic [31:0] cnt_m = 0;
  hazard_sched #(.TimeoutCycles(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_load(id_load), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_load(ex_load),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rsp_rd(lsu_rsp_rd), .redirect(redirect), .pc_stall(pc_stall), .id_stall(id_stall),
    .id_flush(id_flush), .ex_bubble(ex_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .hz_state(hz_state), .stall_count(stall_count), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin : mon
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      check(x.tag, {pc_stall, id_stall, id_flush, ex_bubble, fwd_a_sel, fwd_b_sel, hz_state, timeout_err}, x.v);
      check({x.tag, "_cnt"}, stall_count, x.c);
    end
  end
  task automatic cyc(input string tag, input logic st, input logic fl, input logic [1:0] fa,
                     input logic [1:0] fb, input logic [1:0] hs, input logic to);
    q.push_back('{tag, {st, st, fl, st | fl, fa, fb, hs, to}, cnt_m});
    @(posedge clk);
    #1;
    cnt_m = !rst ? 32'd0 : cnt_m + 32'(st);
  endtask
  task automatic idle();
    {id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_load} = '0;
    {ex_reg_write, ex_load, wb_reg_write, lsu_rsp_valid, redirect} = '0;
    {id_rs1, id_rs2, id_rd, ex_rd, wb_rd, lsu_rsp_rd} = '0;
  endtask
  task automatic ins(input logic ld, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    id_valid = 1'b1; id_load = ld; id_reg_write = 1'b1; id_rd = rd;
    id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; id_rs1 = r1; id_rs2 = r2;
  endtask
  task automatic rsp(input logic [4:0] r);
    lsu_rsp_valid = 1'b1; lsu_rsp_rd = r;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    idle(); rst = 1'b0;
    @(posedge clk); #1;
    ex_reg_write = 1; ex_rd = 7; ins(0, 6, 7, 7);
    cyc("rst", 0, 1, 0, 0, 0, 0);
    rst = 1'b1; idle();
    // load-use RAW
    ins(1, 5, 0, 0); cyc("raw_ld", 0, 0, 0, 0, 0, 0);
    ins(0, 6, 5, 1); ex_reg_write = 1; ex_load = 1; ex_rd = 5; cyc("raw_s1", 1, 0, 0, 0, 0, 0);
    ex_reg_write = 0; ex_load = 0; rsp(5); cyc("raw_s2", 1, 0, 0, 0, 1, 0);
    lsu_rsp_valid = 0; cyc("raw_go", 0, 0, 0, 0, 1, 0);
    idle(); cyc("raw_idle", 0, 0, 0, 0, 0, 0);
    // structural limit
    ins(1, 1, 0, 0); cyc("st_l1", 0, 0, 0, 0, 0, 0);
    ins(1, 2, 0, 0); cyc("st_l2", 0, 0, 0, 0, 0, 0);
    ins(1, 3, 0, 0); cyc("st_full", 1, 0, 0, 0, 0, 0);
    rsp(1); cyc("st_rsp", 1, 0, 0, 0, 1, 0);
    lsu_rsp_valid = 0; cyc("st_go", 0, 0, 0, 0, 1, 0);
    ins(1, 4, 0, 0); cyc("st_cnt2", 1, 0, 0, 0, 0, 0);
    idle(); rsp(2); cyc("st_d2", 0, 0, 0, 0, 1, 0);
    rsp(3); cyc("st_d3", 0, 0, 0, 0, 0, 0);
    // stray response at load_cnt==0 must not underflow
    rsp(9); cyc("uf_rsp", 0, 0, 0, 0, 0, 0);
    lsu_rsp_valid = 0;
    ins(1, 10, 0, 0); cyc("uf_l1", 0, 0, 0, 0, 0, 0);
    ins(1, 11, 0, 0); cyc("uf_l2", 0, 0, 0, 0, 0, 0);
    ins(1, 12, 0, 0); cyc("uf_full", 1, 0, 0, 0, 0, 0);
    idle(); rsp(10); cyc("uf_d1", 0, 0, 0, 0, 1, 0);
    rsp(11); cyc("uf_d2", 0, 0, 0, 0, 0, 0);
    // redirect during stall, then reload while flushing
    idle(); ins(1, 5, 0, 0); cyc("rd_ld", 0, 0, 0, 0, 0, 0);
    ins(0, 6, 5, 0); cyc("rd_stall", 1, 0, 0, 0, 0, 0);
    redirect = 1; cyc("rd_flush", 0, 1, 0, 0, 1, 0);
    redirect = 0; cyc("rd_fl2", 0, 1, 0, 0, 2, 0);
    idle(); cyc("rd_run", 0, 0, 0, 0, 0, 0);
    redirect = 1; cyc("rl_r1", 0, 1, 0, 0, 0, 0);
    cyc("rl_r2", 0, 1, 0, 0, 2, 0);
    redirect = 0; cyc("rl_f", 0, 1, 0, 0, 2, 0);
    cyc("rl_run", 0, 0, 0, 0, 0, 0);
    rsp(5); cyc("rd_clr", 0, 0, 0, 0, 0, 0);
    // forwarding priority
    idle(); id_rs1 = 7; ex_reg_write = 1; ex_rd = 7; wb_reg_write = 1; wb_rd = 7;
    cyc("fw_ex", 0, 0, 1, 0, 0, 0);
    ex_load = 1; cyc("fw_ld", 0, 0, 2, 0, 0, 0);
    ex_load = 0; ex_reg_write = 0; id_rs2 = 7; cyc("fw_wb", 0, 0, 2, 2, 0, 0);
    ex_reg_write = 1; ex_rd = 9; id_rs1 = 9; wb_rd = 8; id_rs2 = 8; cyc("fw_mix", 0, 0, 1, 2, 0, 0);
    wb_rd = 0; id_rs2 = 0; ex_rd = 0; id_rs1 = 0; cyc("fw_x0", 0, 0, 0, 0, 0, 0);
    // set and clear on the same register, then reset mid-stall
    idle(); ins(1, 8, 0, 0); cyc("sc_l8", 0, 0, 0, 0, 0, 0);
    ins(1, 4, 0, 0); rsp(4); cyc("sc_same", 0, 0, 0, 0, 0, 0);
    lsu_rsp_valid = 0; ins(0, 6, 0, 4); cyc("sc_s1", 1, 0, 0, 0, 0, 0);
    cyc("sc_s2", 1, 0, 0, 0, 1, 0);
    ex_reg_write = 1; ex_rd = 4; rst = 0; cyc("sc_rst", 0, 1, 0, 0, 1, 0);
    rst = 1; ex_reg_write = 0; ins(0, 6, 8, 4); cyc("sc_post", 0, 0, 0, 0, 0, 0);
    // timeout after four consecutive stall cycles, sticky afterwards
    idle(); ins(1, 5, 0, 0); cyc("to_ld", 0, 0, 0, 0, 0, 0);
    ins(0, 6, 5, 0); cyc("to_s1", 1, 0, 0, 0, 0, 0);
    cyc("to_s2", 1, 0, 0, 0, 1, 0);
    cyc("to_s3", 1, 0, 0, 0, 1, 0);
    cyc("to_s4", 1, 0, 0, 0, 1, 0);
    cyc("to_s5", 1, 0, 0, 0, 1, 1);
    rsp(5); cyc("to_s6", 1, 0, 0, 0, 1, 1);
    lsu_rsp_valid = 0; cyc("to_go", 0, 0, 0, 0, 1, 1);
    idle(); cyc("to_hold", 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("q_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
